// File: rtl/mod_sub_pipe_pkg.sv
// Shared modular-arithmetic definitions for the add/sub datapath blocks.
package mod_sub_pipe_pkg;

    localparam int BIT_SIZE_DEF = 60;
    localparam int TAG_W_DEF    = 8;
    // Working width for cond_add_q; callers keep their operand width below this.
    localparam int ARITH_MAX_W  = 128;

    // diff carries the borrow at bit w; on borrow, add q back in.
    // Callers keep only the low w bits of the result.
    function automatic logic [ARITH_MAX_W-1:0] cond_add_q(
        input logic [ARITH_MAX_W-1:0] diff,
        input logic [ARITH_MAX_W-1:0] q,
        input int                     w
    );
        return diff[w] ? (diff + q) : diff;
    endfunction

endpackage

// File: rtl/mod_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when the held word drains.
module mod_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // Data is only overwritten by a real word; bubbles leave it stale.
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor M = (A - B) mod q with valid/ready and tag.
// Optional range-error flag out_err under `MODSUB_RANGE_CHECK_EN.
module mod_sub_pipe
    import mod_sub_pipe_pkg::*;
#(
    parameter int BIT_SIZE = BIT_SIZE_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_SIZE-1:0] A,
    input  logic [BIT_SIZE-1:0] B,
    input  logic [BIT_SIZE-1:0] q,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIT_SIZE-1:0] M,
    output logic [TAG_W-1:0]    out_tag
`ifdef MODSUB_RANGE_CHECK_EN
    ,
    output logic                out_err
`endif
);

`ifdef MODSUB_RANGE_CHECK_EN
    localparam int S1_W = 3*BIT_SIZE + TAG_W + 1;
    localparam int S2_W = BIT_SIZE + TAG_W + 1;
`else
    localparam int S1_W = 3*BIT_SIZE + TAG_W;
    localparam int S2_W = BIT_SIZE + TAG_W;
`endif

    logic            s1_valid, s2_adv;
    logic [S1_W-1:0] s1_in, s1_out;
    logic [S2_W-1:0] s2_in, s2_out;

    logic [BIT_SIZE-1:0] s1_a, s1_b, s1_q, m_calc;
    logic [TAG_W-1:0]    s1_tag;
    logic [BIT_SIZE:0]   diff;
    logic [ARITH_MAX_W-1:0] sum;
    logic [ARITH_MAX_W-BIT_SIZE-1:0] unused_sum_hi;

`ifdef MODSUB_RANGE_CHECK_EN
    logic chk, s1_chk;
    assign chk    = (A >= q) || (B >= q) || (q == '0);
    assign s1_in  = {chk, in_tag, q, B, A};
    assign s1_chk = s1_out[S1_W-1];
`else
    assign s1_in  = {in_tag, q, B, A};
`endif

    mod_pipe_stage #(.W(S1_W)) u_s1 (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_in),
        .out_valid(s1_valid),
        .out_ready(s2_adv),
        .out_data (s1_out)
    );

    assign s1_a   = s1_out[BIT_SIZE-1:0];
    assign s1_b   = s1_out[2*BIT_SIZE-1:BIT_SIZE];
    assign s1_q   = s1_out[3*BIT_SIZE-1:2*BIT_SIZE];
    assign s1_tag = s1_out[3*BIT_SIZE+TAG_W-1:3*BIT_SIZE];

    // Borrow lands in diff[BIT_SIZE]; the truncated add of q wraps back into range.
    assign diff = {1'b0, s1_a} - {1'b0, s1_b};
    assign sum  = cond_add_q(ARITH_MAX_W'(diff), ARITH_MAX_W'(s1_q), BIT_SIZE);
    assign {unused_sum_hi, m_calc} = sum;

`ifdef MODSUB_RANGE_CHECK_EN
    assign s2_in = {s1_chk, s1_tag, m_calc};
`else
    assign s2_in = {s1_tag, m_calc};
`endif

    mod_pipe_stage #(.W(S2_W)) u_s2 (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (s1_valid),
        .in_ready (s2_adv),
        .in_data  (s2_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (s2_out)
    );

    assign M       = s2_out[BIT_SIZE-1:0];
    assign out_tag = s2_out[BIT_SIZE+TAG_W-1:BIT_SIZE];
`ifdef MODSUB_RANGE_CHECK_EN
    assign out_err = s2_out[S2_W-1];
`endif

endmodule

// File: doc/mod_sub_pipe.md
Name: mod_sub_pipe

Overview:
- Pipelined modular subtractor: M = (A - B) mod q, for operands already reduced (A, B < q).
- Inverse companion of the modular adder in the NTT/arithmetic datapath; feeds butterfly difference paths.
- Adds a valid/ready handshake with backpressure and a tag passthrough, so it can be chained with other stalling arithmetic blocks.

Parameters:
- BIT_SIZE, 60, operand/modulus width.
- TAG_W, 8, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- A  input  BIT_SIZE  minuend, must be < q.
- B  input  BIT_SIZE  subtrahend, must be < q.
- q  input  BIT_SIZE  modulus, nonzero; sampled per operation.
- in_tag  input  TAG_W  sideband identifier.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- M  output  BIT_SIZE  (A - B) mod q.
- out_tag  output  TAG_W  tag of the operation in M.
- out_err  output  1  range-error flag; present only with the optional feature.

Behaviour:
- Reset: the reset is asynchronous, active-low, on rstn; clock is clk.
  - All stage registers clear: s1_valid=0, out_valid=0, M=0, out_tag=0, out_err=0.
  - in_ready is 1 once out of reset.
- Two-stage pipeline.
  - S1 registers A, B, q and in_tag on an input handshake (in_valid && in_ready).
  - S2 computes and registers M, out_tag and out_valid.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational, no dependence on in_valid).
  - When s2_adv is true, S2 loads from S1: out_valid <= s1_valid.
  - When s1_valid=0, S2 may keep stale M and out_tag, but out_valid=0.
- Latency and throughput:
  - Latency is 2 cycles from input handshake to out_valid=1.
  - Throughput is 1 operation per cycle when out_ready is held high.
- Stall:
  - While out_valid && !out_ready, M, out_tag and out_err hold stable.
  - S1 holds its contents if occupied, and in_ready=!s1_valid.
  - No data is lost or duplicated.
- Simultaneous events:
  - An S1 drain and an S1 refill in the same cycle is legal: full-rate handshake.
  - Output consume and S2 refill in the same cycle is legal.
- Arithmetic, in S2:
  - diff = {1'b0,A} - {1'b0,B}, BIT_SIZE+1 bits.
  - If diff[BIT_SIZE] (borrow) is set: M = diff[BIT_SIZE-1:0] + q, truncated to BIT_SIZE bits.
  - Otherwise: M = diff[BIT_SIZE-1:0].
  - A==B gives M=0. A=0, B=q-1 gives M=1.
- Out-of-range inputs (A>=q or B>=q): the result is unspecified unless the optional feature is enabled, but the handshake is still honoured.
- Reset mid-operation: in-flight operations are discarded; nothing is emitted after rstn deasserts until new inputs are accepted.

Optional Feature:
- Macro: MODSUB_RANGE_CHECK_EN.
- Defined:
  - S1 also registers chk = (A >= q) || (B >= q) || (q == 0).
  - out_err is driven alongside M with the same timing, hold and stall behaviour.
  - M is still computed by the normal rule.
- Undefined: the out_err port and the compare logic are absent.

Decomposition:
- Shared package (e.g. modarith_pkg) holds:
  - the default BIT_SIZE constant, shared with the modular adder;
  - the default TAG_W constant;
  - a conditional-correct function cond_add_q(diff, q), reusable by the adder and the subtractor.
- One sub-module is natural: mod_pipe_stage, a generic valid/ready register slice with payload width parameter.
  - Instantiated twice: once for the S1 payload, once for the S2 payload.
  - The arithmetic sits between the two instances.

Test Plan (q=97, TAG_W=8, out_ready=1 unless noted):
- A=20, B=10, tag=0x01 -> M=10, out_tag=0x01, out_valid exactly 2 cycles after accept.
- A=10, B=20 -> M=87 (borrow path). A=0, B=96 -> M=1. A=55, B=55 -> M=0.
- Back-to-back stream of 8 ops at in_valid=1 -> 8 results in consecutive cycles, in order, tags preserved.
- Backpressure: hold out_ready=0 for 5 cycles with 3 ops offered:
  - M stable throughout;
  - in_ready drops after 2 ops accepted;
  - releasing out_ready drains all 3 in order.
- Reset pulse while 2 ops are in flight -> out_valid=0 and M=0 immediately; no results emitted afterwards until new input.
- With MODSUB_RANGE_CHECK_EN: A=97, B=3 -> out_err=1. A=96, B=3 -> out_err=0 and M=93.
